// File: rtl/acc_register_bank.sv
// Accumulator register bank: general registers, one accumulator (res) and a LIFO save stack for res.
// Optional feature macro: ACC_BANK_REG0_ZERO_EN (reg 0 hardwired to zero, writes to it discarded).
module acc_register_bank #(
  parameter int DATA_W      = 16,
  parameter int NUM_REGS    = 8,
  parameter int SEL_W       = 3,
  parameter int STACK_DEPTH = 4,
  parameter int CNT_W       = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        op,
  input  logic [SEL_W-1:0]  reg_sel,
  input  logic [SEL_W-1:0]  reg_sel_b,
  input  logic [DATA_W-1:0] write_data,
  input  logic              clr_err,
  output logic [DATA_W-1:0] res_val,
  output logic [DATA_W-1:0] reg_val,
  output logic [DATA_W-1:0] reg_val_b,
  output logic [CNT_W-1:0]  stk_count,
  output logic              stk_full,
  output logic              stk_empty,
  output logic              err_ovf,
  output logic              err_unf,
  output logic              err_sel
);

  localparam logic [2:0] OP_NOP    = 3'd0;
  localparam logic [2:0] OP_CPYIN  = 3'd1;
  localparam logic [2:0] OP_CPYOUT = 3'd2;
  localparam logic [2:0] OP_LOAD   = 3'd3;
  localparam logic [2:0] OP_ALUWB  = 3'd4;
  localparam logic [2:0] OP_PUSH   = 3'd5;
  localparam logic [2:0] OP_POP    = 3'd6;
  localparam logic [2:0] OP_SWAP   = 3'd7;

  localparam logic [SEL_W:0]   NUM_REGS_C = (SEL_W+1)'(NUM_REGS);
  localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(STACK_DEPTH);

  logic [DATA_W-1:0] regs_r  [NUM_REGS];
  logic [DATA_W-1:0] stack_r [STACK_DEPTH];
  logic [DATA_W-1:0] res_r;
  logic [CNT_W-1:0]  count_r;
  logic              err_ovf_r, err_unf_r, err_sel_r;

  logic [DATA_W-1:0] rd_a_s, rd_b_s, pop_val_s, reg_wdata_s, res_wdata_s;
  logic              sel_ok_s, reg0_s, full_s, empty_s;
  logic              reg_wr_s, reg_we_s, res_wr_s, push_s, pop_s;
  logic              set_ovf_s, set_unf_s, set_sel_s;

  assign sel_ok_s = ({1'b0, reg_sel} < NUM_REGS_C);
  assign full_s   = (count_r == DEPTH_C);
  assign empty_s  = (count_r == {CNT_W{1'b0}});
`ifdef ACC_BANK_REG0_ZERO_EN
  assign reg0_s   = (reg_sel == {SEL_W{1'b0}});
`else
  assign reg0_s   = 1'b0;
`endif
  // Writes to a hardwired-zero reg 0 are dropped without flagging an error.
  assign reg_we_s = reg_wr_s & ~reg0_s;

  // Combinational read ports and top-of-stack value; out-of-range selects read zero.
  always_comb begin
    rd_a_s    = {DATA_W{1'b0}};
    rd_b_s    = {DATA_W{1'b0}};
    pop_val_s = {DATA_W{1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      if (reg_sel == SEL_W'(i)) rd_a_s = regs_r[i];
      if (reg_sel_b == SEL_W'(i)) rd_b_s = regs_r[i];
    end
`ifdef ACC_BANK_REG0_ZERO_EN
    if (reg_sel == {SEL_W{1'b0}}) rd_a_s = {DATA_W{1'b0}};
    if (reg_sel_b == {SEL_W{1'b0}}) rd_b_s = {DATA_W{1'b0}};
`endif
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (count_r == CNT_W'(i + 1)) pop_val_s = stack_r[i];
    end
  end

  // Opcode decode into write enables, write data and error-set strobes.
  always_comb begin
    reg_wr_s    = 1'b0;
    reg_wdata_s = res_r;
    res_wr_s    = 1'b0;
    res_wdata_s = write_data;
    push_s      = 1'b0;
    pop_s       = 1'b0;
    set_ovf_s   = 1'b0;
    set_unf_s   = 1'b0;
    set_sel_s   = 1'b0;
    case (op)
      OP_NOP: begin end
      OP_CPYIN: begin
        res_wr_s    = 1'b1;
        res_wdata_s = rd_a_s;
      end
      OP_CPYOUT: begin
        if (sel_ok_s) reg_wr_s = 1'b1;
        else          set_sel_s = 1'b1;
      end
      OP_LOAD: begin
        reg_wdata_s = write_data;
        if (sel_ok_s) reg_wr_s = 1'b1;
        else          set_sel_s = 1'b1;
      end
      OP_ALUWB: res_wr_s = 1'b1;
      OP_PUSH: begin
        if (full_s) set_ovf_s = 1'b1;
        else        push_s    = 1'b1;
      end
      OP_POP: begin
        res_wdata_s = pop_val_s;
        if (empty_s) begin
          set_unf_s = 1'b1;
        end else begin
          pop_s    = 1'b1;
          res_wr_s = 1'b1;
        end
      end
      OP_SWAP: begin
        res_wdata_s = rd_a_s;
        if (sel_ok_s) begin
          reg_wr_s = 1'b1;
          res_wr_s = 1'b1;
        end else begin
          set_sel_s = 1'b1;
        end
      end
      default: begin end
    endcase
  end

  // State update; synchronous reset overrides any opcode.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_r[i] <= {DATA_W{1'b0}};
      for (int i = 0; i < STACK_DEPTH; i++) stack_r[i] <= {DATA_W{1'b0}};
      res_r     <= {DATA_W{1'b0}};
      count_r   <= {CNT_W{1'b0}};
      err_ovf_r <= 1'b0;
      err_unf_r <= 1'b0;
      err_sel_r <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (reg_we_s && (reg_sel == SEL_W'(i))) regs_r[i] <= reg_wdata_s;
      end
      for (int i = 0; i < STACK_DEPTH; i++) begin
        if (push_s && (count_r == CNT_W'(i))) stack_r[i] <= res_r;
      end
      if (res_wr_s) res_r <= res_wdata_s;
      if (push_s)     count_r <= count_r + CNT_W'(1);
      else if (pop_s) count_r <= count_r - CNT_W'(1);
      // A new error in the same cycle as clr_err keeps its flag set.
      err_ovf_r <= set_ovf_s | (err_ovf_r & ~clr_err);
      err_unf_r <= set_unf_s | (err_unf_r & ~clr_err);
      err_sel_r <= set_sel_s | (err_sel_r & ~clr_err);
    end
  end

  assign res_val   = res_r;
  assign reg_val   = rd_a_s;
  assign reg_val_b = rd_b_s;
  assign stk_count = count_r;
  assign stk_full  = full_s;
  assign stk_empty = empty_s;
  assign err_ovf   = err_ovf_r;
  assign err_unf   = err_unf_r;
  assign err_sel   = err_sel_r;

endmodule

// File: tb/tb_acc_register_bank.sv
// Scoreboard bench for acc_register_bank (NUM_REGS=6 so select 6/7 are out of range).
// Honours ACC_BANK_REG0_ZERO_EN when defined.
module tb_acc_register_bank;

  localparam logic [2:0] OP_NOP = 3'd0, OP_CPYIN = 3'd1, OP_CPYOUT = 3'd2, OP_LOAD = 3'd3;
  localparam logic [2:0] OP_ALUWB = 3'd4, OP_PUSH = 3'd5, OP_POP = 3'd6, OP_SWAP = 3'd7;
  localparam int K_RES = 0, K_A = 1, K_B = 2, K_CNT = 3, K_ERR = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  op;
  logic [2:0]  reg_sel, reg_sel_b;
  logic [15:0] write_data;
  logic        clr_err;
  logic [15:0] res_val, reg_val, reg_val_b;
  logic [2:0]  stk_count;
  logic        stk_full, stk_empty, err_ovf, err_unf, err_sel;

  typedef struct {
    int          kind;
    logic [15:0] exp;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;

  acc_register_bank #(
    .DATA_W(16), .NUM_REGS(6), .SEL_W(3), .STACK_DEPTH(4), .CNT_W(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .reg_sel(reg_sel), .reg_sel_b(reg_sel_b),
    .write_data(write_data), .clr_err(clr_err), .res_val(res_val), .reg_val(reg_val),
    .reg_val_b(reg_val_b), .stk_count(stk_count), .stk_full(stk_full),
    .stk_empty(stk_empty), .err_ovf(err_ovf), .err_unf(err_unf), .err_sel(err_sel)
  );

  always #5 clk = ~clk;

  // Monitor: drain every queued expectation against the live outputs on the falling edge.
  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      exp_t        e;
      logic [15:0] act;
      e = sb_q.pop_front();
      case (e.kind)
        K_RES:   act = res_val;
        K_A:     act = reg_val;
        K_B:     act = reg_val_b;
        K_CNT:   act = {11'd0, stk_count, stk_full, stk_empty};
        default: act = {13'd0, err_ovf, err_unf, err_sel};
      endcase
      checks++;
      if (act !== e.exp) begin
        failures++;
        $display("FAIL %s actual=%h required=%h", e.name, act, e.exp);
      end
    end
  end

  function automatic logic [15:0] cnt_v(input logic [2:0] c, input logic f, input logic e);
    return {11'd0, c, f, e};
  endfunction

  function automatic logic [15:0] err_v(input logic o, input logic u, input logic s);
    return {13'd0, o, u, s};
  endfunction

  task automatic step(input logic [2:0] o, input logic [2:0] s, input logic [15:0] d,
                      input logic c);
    op = o; reg_sel = s; write_data = d; clr_err = c;
    @(posedge clk);
    #1;
    op = OP_NOP; clr_err = 1'b0;
  endtask

  task automatic expect_v(input int kind, input logic [2:0] s, input logic [15:0] v,
                          input string name);
    if (kind == K_A) reg_sel = s;
    if (kind == K_B) reg_sel_b = s;
    sb_q.push_back('{kind, v, name});
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; op = OP_NOP; reg_sel = 3'd0; reg_sel_b = 3'd0;
    write_data = 16'h0000; clr_err = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: activity, then reset with a LOAD pending
    step(OP_LOAD, 3'd1, 16'h5555, 1'b0);
    step(OP_ALUWB, 3'd0, 16'h7777, 1'b0);
    step(OP_PUSH, 3'd0, 16'h0000, 1'b0);
    step(OP_POP, 3'd0, 16'h0000, 1'b0);
    step(OP_POP, 3'd0, 16'h0000, 1'b0);
    rst_n = 1'b0;
    step(OP_LOAD, 3'd1, 16'h1111, 1'b0);
    rst_n = 1'b1;
    expect_v(K_RES, 3'd0, 16'h0000, "rst_res");
    expect_v(K_B, 3'd1, 16'h0000, "rst_reg1");
    expect_v(K_CNT, 3'd0, cnt_v(3'd0, 1'b0, 1'b1), "rst_cnt");
    expect_v(K_ERR, 3'd0, err_v(1'b0, 1'b0, 1'b0), "rst_err");

    // 2: load / copy / writeback path
    step(OP_LOAD, 3'd3, 16'h1234, 1'b0);
    step(OP_CPYIN, 3'd3, 16'h0000, 1'b0);
    expect_v(K_RES, 3'd0, 16'h1234, "cpyin_res");
    step(OP_ALUWB, 3'd0, 16'hBEEF, 1'b0);
    step(OP_CPYOUT, 3'd5, 16'h0000, 1'b0);
    expect_v(K_RES, 3'd0, 16'hBEEF, "aluwb_res");
    expect_v(K_B, 3'd5, 16'hBEEF, "cpyout_reg5");
    expect_v(K_B, 3'd3, 16'h1234, "reg3_b");
    expect_v(K_A, 3'd3, 16'h1234, "reg3_a");

    // 3: stack fill, overflow, drain, underflow
    for (int i = 0; i < 5; i++) begin
      step(OP_ALUWB, 3'd0, 16'h00A0 + 16'(i), 1'b0);
      step(OP_PUSH, 3'd0, 16'h0000, 1'b0);
    end
    expect_v(K_CNT, 3'd0, cnt_v(3'd4, 1'b1, 1'b0), "stk_full");
    expect_v(K_ERR, 3'd0, err_v(1'b1, 1'b0, 1'b0), "ovf_set");
    expect_v(K_RES, 3'd0, 16'h00A4, "ovf_res_kept");
    for (int i = 3; i >= 0; i--) begin
      step(OP_POP, 3'd0, 16'h0000, 1'b0);
      expect_v(K_RES, 3'd0, 16'h00A0 + 16'(i), "pop_res");
    end
    step(OP_POP, 3'd0, 16'h0000, 1'b0);
    expect_v(K_RES, 3'd0, 16'h00A0, "unf_res_kept");
    expect_v(K_CNT, 3'd0, cnt_v(3'd0, 1'b0, 1'b1), "stk_empty");
    expect_v(K_ERR, 3'd0, err_v(1'b1, 1'b1, 1'b0), "unf_set");
    step(OP_NOP, 3'd0, 16'h0000, 1'b1);
    expect_v(K_ERR, 3'd0, err_v(1'b0, 1'b0, 1'b0), "clr_all");

    // 4: swap exchanges on one edge
    step(OP_LOAD, 3'd2, 16'h0011, 1'b0);
    step(OP_ALUWB, 3'd0, 16'h00FF, 1'b0);
    step(OP_SWAP, 3'd2, 16'h0000, 1'b0);
    expect_v(K_RES, 3'd0, 16'h0011, "swap_res");
    expect_v(K_B, 3'd2, 16'h00FF, "swap_reg2");

    // 5: out-of-range selects and clear priority
    step(OP_LOAD, 3'd7, 16'hABCD, 1'b0);
    expect_v(K_ERR, 3'd0, err_v(1'b0, 1'b0, 1'b1), "sel7_err");
    expect_v(K_A, 3'd7, 16'h0000, "sel7_reads0");
    expect_v(K_B, 3'd6, 16'h0000, "sel6_reads0");
    step(OP_SWAP, 3'd6, 16'h0000, 1'b1);
    expect_v(K_RES, 3'd0, 16'h0011, "swap_oob_res");
    expect_v(K_ERR, 3'd0, err_v(1'b0, 1'b0, 1'b1), "swap_oob_err");
    step(OP_NOP, 3'd0, 16'h0000, 1'b1);
    expect_v(K_ERR, 3'd0, err_v(1'b0, 1'b0, 1'b0), "clr_sel");
    step(OP_POP, 3'd0, 16'h0000, 1'b1);
    expect_v(K_ERR, 3'd0, err_v(1'b0, 1'b1, 1'b0), "clr_vs_unf");

    // 6: register 0 behaviour
    step(OP_NOP, 3'd0, 16'h0000, 1'b1);
    step(OP_LOAD, 3'd0, 16'hFFFF, 1'b0);
`ifdef ACC_BANK_REG0_ZERO_EN
    expect_v(K_A, 3'd0, 16'h0000, "reg0_zero");
    expect_v(K_ERR, 3'd0, err_v(1'b0, 1'b0, 1'b0), "reg0_no_err");
    step(OP_ALUWB, 3'd0, 16'h1234, 1'b0);
    step(OP_SWAP, 3'd0, 16'h0000, 1'b0);
    expect_v(K_RES, 3'd0, 16'h0000, "swap_reg0_res");
    expect_v(K_A, 3'd0, 16'h0000, "swap_reg0_reg");
`else
    expect_v(K_A, 3'd0, 16'hFFFF, "reg0_plain");
    expect_v(K_ERR, 3'd0, err_v(1'b0, 1'b0, 1'b0), "reg0_no_err");
    step(OP_ALUWB, 3'd0, 16'h1234, 1'b0);
    step(OP_SWAP, 3'd0, 16'h0000, 1'b0);
    expect_v(K_RES, 3'd0, 16'hFFFF, "swap_reg0_res");
    expect_v(K_A, 3'd0, 16'h1234, "swap_reg0_reg");
`endif

    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL sb_drain actual=%0d required=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
